// File: rtl/dcm_pkg.sv
// Shared types and constants for the dcmctrl loop sequencer.
// DCM_SCHED_DEADBAND_EN (see dcm_loop_sched) does not affect this package.
package dcm_pkg;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      FWD  = 2'd1,
      REV  = 2'd2
   } dir_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EVAL  = 3'd2,
      WB    = 3'd3,
      NEXT  = 3'd4
   } state_t;

   localparam int unsigned FLG_AT_TARGET = 0;
   localparam int unsigned FLG_FWD       = 1;
   localparam int unsigned FLG_REV       = 2;
   localparam int unsigned FLG_FAULT     = 3;
   localparam int unsigned FLG_OTW       = 4;
   localparam int unsigned FLG_OVERRUN   = 5;

endpackage

// File: rtl/dcm_pwm_gen.sv
// Per-channel duty/direction storage, free-running PWM counter and registered
// motor outputs. Outputs are computed from the next-state duty/dir so a load
// shows up on the pins one clock after the loading cycle.
module dcm_pwm_gen
   import dcm_pkg::*;
#(
   parameter int unsigned NUM_CH = 6,
   parameter int unsigned SPD_W  = 8
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              ld_i,
   input  logic [2:0]        ld_ch_i,
   input  logic [SPD_W-1:0]  ld_duty_i,
   input  dir_t              ld_dir_i,
   output dir_t              dir_o [NUM_CH],
   output logic [NUM_CH-1:0] motor_left_o,
   output logic [NUM_CH-1:0] motor_right_o
);

   logic [SPD_W-1:0]  pwm_q;
   logic [SPD_W-1:0]  duty_q [NUM_CH];
   logic [SPD_W-1:0]  duty_d [NUM_CH];
   dir_t              dir_q  [NUM_CH];
   dir_t              dir_d  [NUM_CH];
   logic [NUM_CH-1:0] left_q, left_d, right_q, right_d;

   always_comb begin
      duty_d  = duty_q;
      dir_d   = dir_q;
      left_d  = '0;
      right_d = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (ld_i && (ld_ch_i == 3'(c))) begin
            duty_d[c] = ld_duty_i;
            dir_d[c]  = ld_dir_i;
         end
         right_d[c] = (dir_d[c] == FWD) && (pwm_q < duty_d[c]);
         left_d[c]  = (dir_d[c] == REV) && (pwm_q < duty_d[c]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pwm_q   <= '0;
         duty_q  <= '{default: '0};
         dir_q   <= '{default: STOP};
         left_q  <= '0;
         right_q <= '0;
      end else begin
         pwm_q   <= pwm_q + 1'b1;
         duty_q  <= duty_d;
         dir_q   <= dir_d;
         left_q  <= left_d;
         right_q <= right_d;
      end
   end

   assign dir_o         = dir_q;
   assign motor_left_o  = left_q;
   assign motor_right_o = right_q;

endmodule

// File: rtl/dcm_loop_sched.sv
// Control-loop sequencer: per tick, fetch/evaluate/write-back each channel.
// Optional macro DCM_SCHED_DEADBAND_EN widens the at-target window to +/-DEADBAND.
module dcm_loop_sched
   import dcm_pkg::*;
#(
   parameter int unsigned NUM_CH   = 6,
   parameter int unsigned POS_W    = 24,
   parameter int unsigned SPD_W    = 8,
   parameter int unsigned TICK_DIV = 1000,
   parameter int unsigned DEADBAND = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              rd_req,
   output logic [2:0]        rd_ch,
   input  logic              rd_ack,
   input  logic [SPD_W-1:0]  rd_tgt_spd,
   input  logic [POS_W-1:0]  rd_tgt_pos,
   input  logic [POS_W-1:0]  rd_cur_pos,
   output logic              wr_req,
   output logic [2:0]        wr_ch,
   output logic [7:0]        wr_flags,
   input  logic              wr_ack,
   input  logic [NUM_CH-1:0] motor_fault,
   input  logic [NUM_CH-1:0] motor_otw,
   output logic [NUM_CH-1:0] motor_left,
   output logic [NUM_CH-1:0] motor_right,
   output logic              overrun
);

   localparam int unsigned TW = $clog2(TICK_DIV);

   state_t            state_q, state_d;
   logic [2:0]        ch_q, ch_d;
   logic [TW-1:0]     tick_q;
   logic              tick;
   logic              rd_req_q, rd_req_d, wr_req_q, wr_req_d;
   logic              overrun_q, overrun_d;
   logic [7:0]        flags_q, flags_d, flags_new;
   logic [SPD_W-1:0]  spd_q, duty_new;
   logic [POS_W-1:0]  tgt_q, cur_q;
   logic signed [POS_W:0] err;
   logic              at_tgt, fault, otw, ld;
   dir_t              req_dir, dir_new, prev_dir;
   dir_t              dir_w [NUM_CH];

   assign tick = (tick_q == TW'(TICK_DIV - 1));

   always_comb begin
      err   = $signed({tgt_q[POS_W-1], tgt_q}) - $signed({cur_q[POS_W-1], cur_q});
      fault = motor_fault[ch_q];
      otw   = motor_otw[ch_q];
      prev_dir = dir_w[ch_q];
`ifdef DCM_SCHED_DEADBAND_EN
      at_tgt = (err <= $signed((POS_W+1)'(DEADBAND))) &&
               (err >= -$signed((POS_W+1)'(DEADBAND)));
`else
      at_tgt = (err == '0);
`endif
      req_dir = at_tgt ? STOP : (err > 0) ? FWD : REV;
      dir_new = req_dir;
      if (fault || (spd_q == '0))
         dir_new = STOP;
      else if ((req_dir != STOP) && (prev_dir != STOP) && (req_dir != prev_dir))
         dir_new = STOP; // reversal passes through STOP for one loop pass
      duty_new = fault ? '0 : otw ? (spd_q >> 1) : spd_q;
      flags_new = '0;
      flags_new[FLG_AT_TARGET] = at_tgt;
      flags_new[FLG_FWD]       = (dir_new == FWD);
      flags_new[FLG_REV]       = (dir_new == REV);
      flags_new[FLG_FAULT]     = fault;
      flags_new[FLG_OTW]       = otw;
      flags_new[FLG_OVERRUN]   = overrun_q;
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      rd_req_d  = rd_req_q;
      wr_req_d  = wr_req_q;
      flags_d   = flags_q;
      overrun_d = overrun_q | (tick && (state_q != IDLE));
      ld        = 1'b0;
      case (state_q)
         IDLE: if (tick) begin
            state_d  = FETCH;
            ch_d     = '0;
            rd_req_d = 1'b1;
         end
         FETCH: if (rd_ack) begin
            rd_req_d = 1'b0;
            state_d  = EVAL;
         end
         EVAL: begin
            ld       = 1'b1;
            flags_d  = flags_new;
            wr_req_d = 1'b1;
            state_d  = WB;
         end
         WB: if (wr_ack) begin
            wr_req_d = 1'b0;
            state_d  = NEXT;
         end
         NEXT: begin
            if (ch_q == 3'(NUM_CH - 1)) begin
               state_d = IDLE;
            end else begin
               ch_d     = ch_q + 3'd1;
               rd_req_d = 1'b1;
               state_d  = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         tick_q    <= '0;
         rd_req_q  <= 1'b0;
         wr_req_q  <= 1'b0;
         overrun_q <= 1'b0;
         flags_q   <= '0;
         spd_q     <= '0;
         tgt_q     <= '0;
         cur_q     <= '0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         tick_q    <= tick ? '0 : tick_q + 1'b1;
         rd_req_q  <= rd_req_d;
         wr_req_q  <= wr_req_d;
         overrun_q <= overrun_d;
         flags_q   <= flags_d;
         if ((state_q == FETCH) && rd_ack) begin
            spd_q <= rd_tgt_spd;
            tgt_q <= rd_tgt_pos;
            cur_q <= rd_cur_pos;
         end
      end
   end

   dcm_pwm_gen #(
      .NUM_CH (NUM_CH),
      .SPD_W  (SPD_W)
   ) u_pwm (
      .clk_i         (clk),
      .reset_i       (reset),
      .ld_i          (ld),
      .ld_ch_i       (ch_q),
      .ld_duty_i     (duty_new),
      .ld_dir_i      (dir_new),
      .dir_o         (dir_w),
      .motor_left_o  (motor_left),
      .motor_right_o (motor_right)
   );

   assign rd_req   = rd_req_q;
   assign rd_ch    = ch_q;
   assign wr_req   = wr_req_q;
   assign wr_ch    = ch_q;
   assign wr_flags = flags_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_dcm_loop_sched.sv
// Directed self-checking bench for dcm_loop_sched (TICK_DIV reduced to 64).
module tb_dcm_loop_sched;

   localparam int unsigned NUM_CH = 6;
   localparam int unsigned POS_W  = 24;
   localparam int unsigned SPD_W  = 8;
   localparam int unsigned TDIV   = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              rd_req, rd_ack, wr_req, wr_ack, overrun;
   logic [2:0]        rd_ch, wr_ch;
   logic [SPD_W-1:0]  rd_tgt_spd;
   logic [POS_W-1:0]  rd_tgt_pos, rd_cur_pos;
   logic [7:0]        wr_flags;
   logic [NUM_CH-1:0] motor_fault, motor_otw, motor_left, motor_right;

   logic [SPD_W-1:0]  spd_tab [NUM_CH];
   logic [POS_W-1:0]  tgt_tab [NUM_CH];
   logic [POS_W-1:0]  cur_tab [NUM_CH];
   logic              rd_en, wr_en;
   logic [7:0]        flags_cap [NUM_CH];
   int                pass_cnt;
   int                vectors, miscompares;
   int                r_cnt, l_cnt, both_cnt;
   logic [7:0]        exp_f;

   always #5 clk = ~clk;

   assign rd_ack     = rd_req && rd_en;
   assign wr_ack     = wr_req && wr_en;
   assign rd_tgt_spd = (rd_ch < 3'd6) ? spd_tab[rd_ch] : '0;
   assign rd_tgt_pos = (rd_ch < 3'd6) ? tgt_tab[rd_ch] : '0;
   assign rd_cur_pos = (rd_ch < 3'd6) ? cur_tab[rd_ch] : '0;

   always @(posedge clk) begin
      if (wr_req && wr_ack && (wr_ch < 3'd6)) begin
         flags_cap[wr_ch] <= wr_flags;
         if (wr_ch == 3'(NUM_CH - 1)) pass_cnt <= pass_cnt + 1;
      end
   end

   dcm_loop_sched #(
      .NUM_CH   (NUM_CH),
      .POS_W    (POS_W),
      .SPD_W    (SPD_W),
      .TICK_DIV (TDIV),
      .DEADBAND (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rd_req      (rd_req),
      .rd_ch       (rd_ch),
      .rd_ack      (rd_ack),
      .rd_tgt_spd  (rd_tgt_spd),
      .rd_tgt_pos  (rd_tgt_pos),
      .rd_cur_pos  (rd_cur_pos),
      .wr_req      (wr_req),
      .wr_ch       (wr_ch),
      .wr_flags    (wr_flags),
      .wr_ack      (wr_ack),
      .motor_fault (motor_fault),
      .motor_otw   (motor_otw),
      .motor_left  (motor_left),
      .motor_right (motor_right),
      .overrun     (overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns at the negedge just after the last channel of a pass is written.
   task automatic wait_pass(input string tag);
      int start;
      bit done;
      start = pass_cnt;
      done  = 1'b0;
      for (int i = 0; i < 4 * TDIV; i++) begin
         @(negedge clk);
         if (pass_cnt != start) begin
            done = 1'b1;
            break;
         end
      end
      check(tag, {31'd0, done}, 32'd1);
   endtask

   task automatic wait_rd_req(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4 * TDIV; i++) begin
         @(negedge clk);
         if (rd_req) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, {31'd0, seen}, 32'd1);
   endtask

   task automatic count_pwm(input int c, output int r, output int l, output int b);
      r = 0; l = 0; b = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (motor_right[c]) r++;
         if (motor_left[c]) l++;
         if (motor_right[c] && motor_left[c]) b++;
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0; pass_cnt = 0;
      reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
      motor_fault = '0; motor_otw = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         spd_tab[i] = '0; tgt_tab[i] = '0; cur_tab[i] = '0; flags_cap[i] = 8'hFF;
      end

      // 1: reset state
      repeat (100) @(negedge clk);
      check("rst_left",    32'(motor_left),  32'd0);
      check("rst_right",   32'(motor_right), 32'd0);
      check("rst_rd_req",  32'(rd_req),      32'd0);
      check("rst_wr_req",  32'(wr_req),      32'd0);
      check("rst_overrun", 32'(overrun),     32'd0);

      // 2: ch0 forward at duty 100
      spd_tab[0] = 8'd100; tgt_tab[0] = 24'd200; cur_tab[0] = 24'd0;
      rd_en = 1'b1; wr_en = 1'b1;
      reset = 1'b0;
      wait_pass("p2_pass");
      check("p2_flags0", 32'(flags_cap[0]), 32'h02);
      for (int c = 1; c < NUM_CH; c++) check("p2_flags_stop", 32'(flags_cap[c]), 32'h01);
      count_pwm(0, r_cnt, l_cnt, both_cnt);
      check("p2_right_duty", 32'(r_cnt), 32'd100);
      check("p2_left_off",   32'(l_cnt), 32'd0);
      check("p2_both",       32'(both_cnt), 32'd0);

      // 3: reversal goes through STOP first
      wait_pass("p3_sync");
      cur_tab[0] = 24'd300;
      wait_pass("p3_pass1");
      check("p3_flags_stop", 32'(flags_cap[0]), 32'h00);
      check("p3_right_off",  32'(motor_right[0]), 32'd0);
      check("p3_left_off",   32'(motor_left[0]),  32'd0);
      wait_pass("p3_pass2");
      check("p3_flags_rev",  32'(flags_cap[0]), 32'h04);
      count_pwm(0, r_cnt, l_cnt, both_cnt);
      check("p3_left_duty",  32'(l_cnt), 32'd100);
      check("p3_right_zero", 32'(r_cnt), 32'd0);

      // 4: back to FWD, then fault, then otw
      wait_pass("p4_sync");
      cur_tab[0] = 24'd0;
      wait_pass("p4_pass1");
      check("p4_rev_to_stop", 32'(flags_cap[0]), 32'h00);
      wait_pass("p4_pass2");
      check("p4_fwd", 32'(flags_cap[0]), 32'h02);
      motor_fault[0] = 1'b1;
      wait_pass("p4_fault_pass");
      check("p4_fault_flags", 32'(flags_cap[0]), 32'h08);
      check("p4_fault_right", 32'(motor_right[0]), 32'd0);
      check("p4_fault_left",  32'(motor_left[0]),  32'd0);
      motor_fault[0] = 1'b0; motor_otw[0] = 1'b1;
      wait_pass("p4_otw_pass");
      check("p4_otw_flags", 32'(flags_cap[0]), 32'h12);
      count_pwm(0, r_cnt, l_cnt, both_cnt);
      check("p4_otw_duty", 32'(r_cnt), 32'd50);

      // 5: at-target and deadband edge
      motor_otw[0] = 1'b0; cur_tab[0] = 24'd200;
      wait_pass("p5_pass1");
      check("p5_at_target", 32'(flags_cap[0]), 32'h01);
      cur_tab[0] = 24'd198;
      wait_pass("p5_pass2");
`ifdef DCM_SCHED_DEADBAND_EN
      exp_f = 8'h01;
`else
      exp_f = 8'h02;
`endif
      check("p5_deadband", 32'(flags_cap[0]), 32'(exp_f));

      // 6: overrun while fetch is stalled, then reset mid-FETCH
      rd_en = 1'b0;
      wait_rd_req("p6_rd_req");
      repeat (2 * TDIV) @(negedge clk);
      check("p6_overrun_set", 32'(overrun), 32'd1);
      rd_en = 1'b1;
      wait_pass("p6_pass");
      check("p6_overrun_sticky", 32'(overrun), 32'd1);
      check("p6_flags_ovr", 32'(flags_cap[0]), 32'(exp_f | 8'h20));
      rd_en = 1'b0;
      wait_rd_req("p6_rd_req2");
      reset = 1'b1;
      @(negedge clk);
      check("p6_rst_rd_req",  32'(rd_req),  32'd0);
      check("p6_rst_overrun", 32'(overrun), 32'd0);
      check("p6_rst_outputs", 32'({motor_left, motor_right}), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0; rd_en = 1'b1;
      wait_pass("p6_post_pass");
      check("p6_post_flags", 32'(flags_cap[0]), 32'(exp_f));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
